// File: rtl/fifo_ctrl.sv
// fifo_ctrl: circular-buffer FIFO controller in front of a 16x5 registered-read memory
// Ports: clk/rst (sync, active high); push/data_in producer side; pop/data_out/valid_out consumer side;
// write_rq/w_address/write_data and read_rq/r_address/read_data to the memory;
// count plus full/empty/almost_full/almost_empty status; sticky err_overflow/err_underflow.
module fifo_ctrl #(
  parameter int DATA_WIDTH   = 5,
  parameter int ADDR_WIDTH   = 4,
  parameter int DEPTH        = 8,
  parameter int ALMOST_FULL  = 6,
  parameter int ALMOST_EMPTY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  write_rq,
  output logic [ADDR_WIDTH-1:0] w_address,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic                  read_rq,
  output logic [ADDR_WIDTH-1:0] r_address,
  input  logic [DATA_WIDTH-1:0] read_data,
  output logic [ADDR_WIDTH-1:0] count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  err_overflow,
  output logic                  err_underflow
);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] FULL_CNT = ADDR_WIDTH'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] AF_CNT = ADDR_WIDTH'(ALMOST_FULL);
  localparam logic [ADDR_WIDTH-1:0] AE_CNT = ADDR_WIDTH'(ALMOST_EMPTY);
  localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic push_ok, pop_ok;
  always_comb begin
    full = count == FULL_CNT;
    empty = count == '0;
    almost_full = count >= AF_CNT;
    almost_empty = count <= AE_CNT;
    push_ok = push & ~full & ~rst;
    pop_ok = pop & ~empty & ~rst;
    write_rq = push_ok;
    w_address = wr_ptr;
    write_data = data_in;
    read_rq = pop_ok;
    r_address = rd_ptr;
    data_out = read_data;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      valid_out <= 1'b0;
      err_overflow <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr == LAST ? '0 : wr_ptr + ONE;
      if (pop_ok) rd_ptr <= rd_ptr == LAST ? '0 : rd_ptr + ONE;
      count <= count + ADDR_WIDTH'(push_ok) - ADDR_WIDTH'(pop_ok);
      valid_out <= pop_ok;
      if (push & full) err_overflow <= 1'b1;
      if (pop & empty) err_underflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: self-checking bench for fifo_ctrl with a registered-read memory model
module tb_fifo_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic push = 1'b0;
  logic pop = 1'b0;
  logic [4:0] data_in = '0;
  logic [4:0] data_out, write_data, read_data;
  logic [3:0] w_address, r_address, count;
  logic valid_out, write_rq, read_rq, full, empty, almost_full, almost_empty, err_overflow, err_underflow;
  int checks = 0;
  int errors = 0;
  logic [4:0] mem [16];
  logic [4:0] rd_q = '0;
  logic [4:0] m_q [$];
  logic [4:0] exp_q [$];
  logic m_valid = 1'b0;
  logic mon_en = 1'b0;
  always #5 clk = ~clk;
  fifo_ctrl dut (
    .clk(clk), .rst(rst), .push(push), .data_in(data_in), .pop(pop),
    .data_out(data_out), .valid_out(valid_out),
    .write_rq(write_rq), .w_address(w_address), .write_data(write_data),
    .read_rq(read_rq), .r_address(r_address), .read_data(read_data),
    .count(count), .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .err_overflow(err_overflow), .err_underflow(err_underflow)
  );
  always @(posedge clk) begin
    if (write_rq) mem[w_address] <= write_data;
    if (read_rq) rd_q <= mem[r_address];
  end
  assign read_data = rd_q;
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (valid_out !== m_valid) begin
        errors++;
        $display("FAIL valid_out: got %b want %b at %0t", valid_out, m_valid, $time);
      end else if (m_valid) begin
        logic [4:0] e;
        e = exp_q.pop_front();
        checks++;
        if (data_out !== e) begin
          errors++;
          $display("FAIL data_out: got %0d want %0d at %0t", data_out, e, $time);
        end
      end
    end
  end
  task automatic drive(input logic p, input logic [4:0] d, input logic q);
    push = p;
    data_in = d;
    pop = q;
    #1;
  endtask
  task automatic tick();
    logic pok, qok;
    pok = push && m_q.size() != 8 && !rst;
    qok = pop && m_q.size() != 0 && !rst;
    @(posedge clk);
    if (rst) begin
      m_q.delete();
      exp_q.delete();
      m_valid = 1'b0;
    end else begin
      if (qok) exp_q.push_back(m_q.pop_front());
      if (pok) m_q.push_back(data_in);
      m_valid = qok;
    end
    #1;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 5'd0, 1'b0);
    tick();
    rst = 1'b0;
    mon_en = 1'b1;
    checks++;
    if (count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
    checks++;
    if ({empty, almost_empty, full, almost_full} !== 4'b1100) begin
      errors++; $display("FAIL reset_flags: got %b want 1100", {empty, almost_empty, full, almost_full});
    end
    checks++;
    if ({valid_out, err_overflow, err_underflow} !== 3'b000) begin
      errors++; $display("FAIL reset_status: got %b want 000", {valid_out, err_overflow, err_underflow});
    end
  endtask
  task automatic test_fill();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 5'(i), 1'b0);
      checks++;
      if ({write_rq, read_rq, w_address, write_data} !== {1'b1, 1'b0, 4'(i), 5'(i)}) begin
        errors++;
        $display("FAIL fill_write[%0d]: got rq=%b rd=%b addr=%0d data=%0d want rq=1 rd=0 addr=%0d data=%0d",
                 i, write_rq, read_rq, w_address, write_data, i, i);
      end
      tick();
      checks++;
      if (almost_full !== (i + 1 >= 6)) begin
        errors++; $display("FAIL fill_almost_full[%0d]: got %b want %b", i, almost_full, i + 1 >= 6);
      end
    end
    checks++;
    if ({count, full, empty} !== {4'd8, 1'b1, 1'b0}) begin
      errors++; $display("FAIL fill_end: got count=%0d full=%b empty=%b want 8 1 0", count, full, empty);
    end
  endtask
  task automatic test_overflow();
    drive(1'b1, 5'd9, 1'b0);
    checks++;
    if (write_rq !== 1'b0) begin errors++; $display("FAIL ovf_write_rq: got %b want 0", write_rq); end
    tick();
    drive(1'b0, 5'd0, 1'b0);
    checks++;
    if ({err_overflow, count, w_address} !== {1'b1, 4'd8, 4'd0}) begin
      errors++; $display("FAIL ovf_state: got err=%b count=%0d waddr=%0d want 1 8 0", err_overflow, count, w_address);
    end
  endtask
  task automatic test_drain();
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 5'd0, 1'b1);
      checks++;
      if ({read_rq, r_address} !== {1'b1, 4'(i)}) begin
        errors++; $display("FAIL drain_read[%0d]: got rq=%b addr=%0d want 1 %0d", i, read_rq, r_address, i);
      end
      tick();
    end
    drive(1'b0, 5'd0, 1'b0);
    checks++;
    if ({count, empty, almost_empty} !== {4'd0, 1'b1, 1'b1}) begin
      errors++; $display("FAIL drain_end: got count=%0d empty=%b ae=%b want 0 1 1", count, empty, almost_empty);
    end
    tick();
  endtask
  task automatic test_underflow();
    drive(1'b0, 5'd0, 1'b1);
    checks++;
    if (read_rq !== 1'b0) begin errors++; $display("FAIL unf_read_rq: got %b want 0", read_rq); end
    tick();
    drive(1'b0, 5'd0, 1'b0);
    checks++;
    if ({err_underflow, valid_out, count} !== {1'b1, 1'b0, 4'd0}) begin
      errors++; $display("FAIL unf_state: got err=%b valid=%b count=%0d want 1 0 0", err_underflow, valid_out, count);
    end
  endtask
  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) begin drive(1'b1, 5'(10 + i), 1'b0); tick(); end
    for (int i = 0; i < 5; i++) begin drive(1'b0, 5'd0, 1'b1); tick(); end
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 5'(20 + i), 1'b1);
      checks++;
      if ({write_rq, w_address, read_rq} !== {1'b1, 4'((5 + i) % 8), i != 0}) begin
        errors++;
        $display("FAIL wrap_req[%0d]: got wrq=%b waddr=%0d rrq=%b want 1 %0d %b",
                 i, write_rq, w_address, read_rq, (5 + i) % 8, i != 0);
      end
      tick();
      checks++;
      if (count !== 4'd1 || 32'(count) !== m_q.size()) begin
        errors++; $display("FAIL wrap_count[%0d]: got %0d want 1", i, count);
      end
    end
    drive(1'b0, 5'd0, 1'b1);
    tick();
    drive(1'b0, 5'd0, 1'b0);
    tick();
    checks++;
    if ({count, empty, err_underflow} !== {4'd0, 1'b1, 1'b1}) begin
      errors++; $display("FAIL wrap_end: got count=%0d empty=%b unf=%b want 0 1 1", count, empty, err_underflow);
    end
  endtask
  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin drive(1'b1, 5'(30 + i), 1'b0); tick(); end
    rst = 1'b1;
    drive(1'b1, 5'd17, 1'b1);
    checks++;
    if ({write_rq, read_rq} !== 2'b00) begin
      errors++; $display("FAIL rst_mid_req: got wrq=%b rrq=%b want 0 0", write_rq, read_rq);
    end
    tick();
    rst = 1'b0;
    drive(1'b0, 5'd0, 1'b0);
    checks++;
    if ({count, empty, valid_out, err_overflow, err_underflow} !== {4'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL rst_mid_state: got count=%0d empty=%b valid=%b ovf=%b unf=%b want 0 1 0 0 0",
               count, empty, valid_out, err_overflow, err_underflow);
    end
    drive(1'b1, 5'd27, 1'b0);
    checks++;
    if ({write_rq, w_address} !== {1'b1, 4'd0}) begin
      errors++; $display("FAIL rst_mid_push: got wrq=%b waddr=%0d want 1 0", write_rq, w_address);
    end
    tick();
    drive(1'b0, 5'd0, 1'b1);
    tick();
    drive(1'b0, 5'd0, 1'b0);
    tick();
  endtask
  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_underflow();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_leftover: got %0d want 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
